operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the register file (built from the team's DFF cells).
- Drives the register-file read addresses, latches both operands plus the decoded op into an output register, and hands them to the ALU over a valid/ready handshake.
- Keeps a per-register busy scoreboard and forwards same-cycle write-back data, so the ALU never receives stale operands.

Parameters:
- DATA_W, 8, operand/register width in bits
- NREG, 16, number of architectural registers
- ADDR_W, 4, register address width; must equal clog2(NREG)
- OP_W, 4, opcode width passed through untouched

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream (decode) presents an instruction
- in_ready  output  1  stage accepts the instruction this cycle
- in_op  input  OP_W  opcode
- in_rs1  input  ADDR_W  source register A
- in_rs2  input  ADDR_W  source register B
- in_rd  input  ADDR_W  destination register
- rf_raddr1  output  ADDR_W  register-file read port 1 address (= in_rs1, combinational)
- rf_raddr2  output  ADDR_W  register-file read port 2 address (= in_rs2, combinational)
- rf_rdata1  input  DATA_W  register-file read data 1 (combinational read)
- rf_rdata2  input  DATA_W  register-file read data 2
- wb_en  input  1  write-back strobe; the same signal writes the register file this cycle
- wb_addr  input  ADDR_W  write-back register
- wb_data  input  DATA_W  write-back value
- out_valid  output  1  operands valid to the ALU
- out_ready  input  1  ALU accepts
- out_op  output  OP_W  latched opcode
- out_rd  output  ADDR_W  latched destination register
- out_a  output  DATA_W  latched operand A
- out_b  output  DATA_W  latched operand B

Behaviour:
- Reset, sampled on the rising clk edge while reset=1:
  - out_valid=0; out_op, out_rd, out_a, out_b = 0.
  - All busy bits = 0.
  - Reset mid-operation discards any held instruction and all pending-write tracking.
- Output-register state machine (two states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; the output holds stable until out_ready=1.
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with out_ready=1 (back-to-back, one instruction per cycle).
  - FULL→EMPTY on out_ready=1 with no accept.
  - FULL with out_ready=0 holds and accept is blocked.
- Forwarding:
  - opA = (wb_en && wb_addr==in_rs1) ? wb_data : rf_rdata1.
  - opB is formed the same way from in_rs2 and rf_rdata2.
- Hazard:
  - srcA_ok = !busy[in_rs1] || (wb_en && wb_addr==in_rs1). srcB_ok is formed likewise.
  - dst_ok = !busy[in_rd] || (wb_en && wb_addr==in_rd). One outstanding write per register; WAW stalls.
- Readiness:
  - in_ready = (state==EMPTY || out_ready) && srcA_ok && srcB_ok && dst_ok.
  - Accept = in_valid && in_ready.
- Latency: an instruction accepted at edge N appears on the out_* signals after edge N (1 cycle).
- Scoreboard update each edge:
  - wb_en clears busy[wb_addr].
  - Accept sets busy[in_rd].
  - When both target the same register, the set wins (the new producer is pending).
  - wb_en to a non-busy register changes no busy bit; the register file still takes the write.
- No combinational path from out_ready to out_* data; in_ready does depend combinationally on out_ready and on wb_*.
- Arithmetic: none; the stage is pure routing. Widths must match exactly, with no truncation or extension.

Decomposition:
- Shared package: DATA_W, NREG, ADDR_W and OP_W defaults; state encoding EMPTY=1'b0, FULL=1'b1.
- One natural sub-module, busy_scoreboard: an NREG-bit vector with set/clear ports and two read ports plus a dst read port. It is built from the existing DFF cells with synchronous reset.
- The forwarding muxes and the output register stay in the top level.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then release → out_valid=0, all out_* = 0, in_ready=1 with in_valid=0 and out_ready=1.
- Basic issue: R1=5, R2=3 in the register file; issue op=2, rs1=1, rs2=2, rd=3 with out_ready=1 → next cycle out_valid=1, out_a=5, out_b=3, out_rd=3, out_op=2.
- RAW stall:
  - After the issue above, issue rs1=3 with no write-back → in_ready=0 each cycle.
  - Assert wb_en, wb_addr=3, wb_data=8'h2A → accepted that same cycle with out_a=8'h2A next cycle.
- Backpressure: out_ready=0 while FULL with a valid new instruction → in_ready=0 and out_* unchanged for 3 cycles; raising out_ready accepts the new instruction in that cycle.
- Same-cycle set/clear: busy[4]=1; issue rd=4 while wb_en=1, wb_addr=4 → accepted and busy[4] stays 1 (a following read of R4 stalls).
- Reset mid-stall: reset asserted while FULL and busy[3]=1 → next cycle out_valid=0; an instruction reading R3 is accepted immediately.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and output-register state encoding for the operand fetch stage.
package operand_fetch_stage_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_NREG   = 16;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_OP_W   = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/operand_fetch_stage_busy_scoreboard.sv
// Per-register pending-write tracker: one busy bit per architectural register,
// with a set port (new producer issued) and a clear port (write-back).
module operand_fetch_stage_busy_scoreboard
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  input  logic [ADDR_W-1:0] i_raddr_d,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic              o_busy_d
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Clear applied before set so a same-cycle retire + reissue leaves the bit pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_busy_a = r_busy[i_raddr_a];
  assign o_busy_b = r_busy[i_raddr_b];
  assign o_busy_d = r_busy[i_raddr_d];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, forwards same-cycle write-back data,
// stalls on pending writes, and registers operands for the ALU handshake.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  if (ADDR_W != 32'($clog2(NREG))) begin : g_bad_addr_w
    $error("ADDR_W must equal clog2(NREG)");
  end

  state_e            r_state;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic              w_busy_a;
  logic              w_busy_b;
  logic              w_busy_d;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic              w_fwd_d;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_slot_free;
  logic              w_accept;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // Write-back hits bypass the register file read, which still shows the old value.
  assign w_fwd_a = wb_en && (wb_addr == in_rs1);
  assign w_fwd_b = wb_en && (wb_addr == in_rs2);
  assign w_fwd_d = wb_en && (wb_addr == in_rd);
  assign w_op_a  = w_fwd_a ? wb_data : rf_rdata1;
  assign w_op_b  = w_fwd_b ? wb_data : rf_rdata2;

  assign w_slot_free = (r_state == ST_EMPTY) || out_ready;
  assign in_ready    = w_slot_free
                    && (!w_busy_a || w_fwd_a)
                    && (!w_busy_b || w_fwd_b)
                    && (!w_busy_d || w_fwd_d);
  assign w_accept    = in_valid && in_ready;

  operand_fetch_stage_busy_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_busy_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (w_accept),
    .i_set_addr (in_rd),
    .i_clr_en   (wb_en),
    .i_clr_addr (wb_addr),
    .i_raddr_a  (in_rs1),
    .i_raddr_b  (in_rs2),
    .i_raddr_d  (in_rd),
    .o_busy_a   (w_busy_a),
    .o_busy_b   (w_busy_b),
    .o_busy_d   (w_busy_d)
  );

  // Output register: loads on accept, drains when the ALU takes it, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_accept) begin
      r_state <= ST_FULL;
      r_op    <= in_op;
      r_rd    <= in_rd;
      r_a     <= w_op_a;
      r_b     <= w_op_b;
    end else if (out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_op    = r_op;
  assign out_rd    = r_rd;
  assign out_a     = r_a;
  assign out_b     = r_b;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register file.
module tb_operand_fetch_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [3:0] in_rs1;
  logic [3:0] in_rs2;
  logic [3:0] in_rd;
  logic [3:0] rf_raddr1;
  logic [3:0] rf_raddr2;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic       wb_en;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_op;
  logic [3:0] out_rd;
  logic [7:0] out_a;
  logic [7:0] out_b;

  logic [7:0] rf [16];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  operand_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] op,
                         input logic [3:0] rd, input logic [7:0] a, input logic [7:0] b);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_op"},    32'(out_op),    32'(op));
    chk({tag, "_rd"},    32'(out_rd),    32'(rd));
    chk({tag, "_a"},     32'(out_a),     32'(a));
    chk({tag, "_b"},     32'(out_b),     32'(b));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[1] = 8'h05;
    rf[2] = 8'h03;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

    // Reset held two cycles
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_out("reset", 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Basic issue: R3 <- op2(R1, R2)
    issue(4'd2, 4'd1, 4'd2, 4'd3);
    #1;
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    chk("basic_raddr1", 32'(rf_raddr1), 32'd1);
    chk("basic_raddr2", 32'(rf_raddr2), 32'd2);
    tick();
    chk_out("basic", 1'b1, 4'd2, 4'd3, 8'h05, 8'h03);

    // RAW on R3 with no write-back stalls; stage drains meanwhile
    issue(4'd5, 4'd3, 4'd1, 4'd6);
    #1;
    chk("raw_stall0", 32'(in_ready), 32'd0);
    tick();
    chk("raw_stall1", 32'(in_ready), 32'd0);
    chk("raw_drained", 32'(out_valid), 32'd0);
    tick();
    chk("raw_stall2", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 8'h2A;
    #1;
    chk("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0;
    chk_out("raw_fwd", 1'b1, 4'd5, 4'd6, 8'h2A, 8'h05);

    // Backpressure: FULL with out_ready low blocks accept and holds outputs
    out_ready = 1'b0;
    issue(4'd7, 4'd1, 4'd2, 4'd8);
    #1;
    chk("bp_ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk_out("bp_hold", 1'b1, 4'd5, 4'd6, 8'h2A, 8'h05);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_accept", 1'b1, 4'd7, 4'd8, 8'h05, 8'h03);

    // Same-cycle set/clear on R4: set wins, R4 stays pending
    issue(4'd1, 4'd0, 4'd0, 4'd4);
    tick();
    chk("sc_first_rd", 32'(out_rd), 32'd4);
    issue(4'd3, 4'd1, 4'd4, 4'd4);
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 8'h77;
    #1;
    chk("sc_ready", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0;
    chk_out("sc_accept", 1'b1, 4'd3, 4'd4, 8'h05, 8'h77);
    issue(4'd6, 4'd4, 4'd1, 4'd9);
    #1;
    chk("sc_r4_still_busy", 32'(in_ready), 32'd0);

    // Reset mid-stall: R3 pending, stage FULL
    issue(4'd8, 4'd1, 4'd2, 4'd3);
    #1;
    chk("rst_prep_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rst_prep_valid", 32'(out_valid), 32'd1);
    issue(4'd9, 4'd3, 4'd4, 4'd10);
    #1;
    chk("rst_stall", 32'(in_ready), 32'd0);
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    issue(4'd9, 4'd3, 4'd4, 4'd4);
    #1;
    chk("rst_r3_free", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("rst_after", 1'b1, 4'd9, 4'd4, 8'h2A, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
